// File: rtl/mips_mem_if.sv
// Unified instruction/data memory port: request/ready handshake with arbitrary wait states.
// The core drives the master side; the memory (or bench model) drives the slave side.
interface mips_mem_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ready);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_rdata, mem_ready);
endinterface

// File: rtl/mips_multi_cycle_core.sv
// Self-sequencing multi-cycle MIPS core with a memory-mapped GPIO output register.
// Optional feature: define MIPS_MC_BNE_EN to decode opcode 0x05 (bne) as an inverted branch.
module mips_multi_cycle_core #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned GPIO_WIDTH   = 8,
  parameter logic [31:0] GPIO_ADDR    = 32'hFFFF_0000,
  parameter int unsigned WAIT_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_mem_if.master            bus,
  output logic [GPIO_WIDTH-1:0] GPIO_o,
  output logic                  halted,
  output logic                  timeout
);

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, MEMADR, MEMRD, MEMWB, MEMWR,
    ALUWB, ADDI, ADDIWB, BRANCH, JUMP, HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int unsigned   WCW       = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_TIMEOUT - 1);

  state_t          state;
  logic [31:0]     pc, ir, a, b, alu_out, mdr;
  logic [31:0]     regs [32];
  logic [WCW-1:0]  wait_cnt;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sx;
  logic        gpio_hit, mem_busy, take_branch;
  logic [31:0] r_result;
  logic        r_legal;

  assign opcode   = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign imm_sx   = {{16{ir[15]}}, ir[15:0]};
  assign gpio_hit = (alu_out == GPIO_ADDR);

`ifdef MIPS_MC_BNE_EN
  assign take_branch = (opcode == OP_BNE) ? (a != b) : (a == b);
`else
  assign take_branch = (a == b);
`endif

  // Bus outputs decode straight from state so a reset drops a pending request in the same cycle.
  assign mem_busy      = (state == FETCH) || (state == MEMRD) || ((state == MEMWR) && !gpio_hit);
  assign bus.mem_req   = !reset && mem_busy;
  assign bus.mem_we    = !reset && (state == MEMWR) && !gpio_hit;
  assign bus.mem_addr  = (state == FETCH) ? pc : alu_out;
  assign bus.mem_wdata = b;

  // NOTE: every output of an always_comb gets a default first, otherwise unlisted funct codes infer latches.
  always_comb begin
    r_result = '0;
    r_legal  = 1'b1;
    unique case (funct)
      6'h20:   r_result = a + b;
      6'h22:   r_result = a - b;
      6'h24:   r_result = a & b;
      6'h25:   r_result = a | b;
      6'h2A:   r_result = {31'b0, $signed(a) < $signed(b)};
      default: r_legal  = 1'b0;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      ir       <= '0;
      a        <= '0;
      b        <= '0;
      alu_out  <= '0;
      mdr      <= '0;
      wait_cnt <= '0;
      GPIO_o   <= '0;
      halted   <= 1'b0;
      timeout  <= 1'b0;
      // NOTE: the register file is reset explicitly, so it maps to flops rather than a RAM macro.
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      unique case (state)
        FETCH: if (bus.mem_ready) begin
          ir    <= bus.mem_rdata;
          pc    <= pc + 32'd4;
          state <= DECODE;
        end
        DECODE: begin
          a       <= regs[rs];
          b       <= regs[rt];
          alu_out <= pc + (imm_sx << 2);
          unique case (opcode)
            OP_RTYPE:      state <= EXEC_R;
            OP_LW, OP_SW:  state <= MEMADR;
            OP_BEQ:        state <= BRANCH;
`ifdef MIPS_MC_BNE_EN
            OP_BNE:        state <= BRANCH;
`endif
            OP_ADDI:       state <= ADDI;
            OP_J:          state <= JUMP;
            default: begin
              state  <= HALT;
              halted <= 1'b1;
            end
          endcase
        end
        EXEC_R: if (r_legal) begin
          alu_out <= r_result;
          state   <= ALUWB;
        end else begin
          state  <= HALT;
          halted <= 1'b1;
        end
        ALUWB: begin
          if (rd != 5'd0) regs[rd] <= alu_out;
          state <= FETCH;
        end
        MEMADR: begin
          alu_out <= a + imm_sx;
          state   <= (opcode == OP_LW) ? MEMRD : MEMWR;
        end
        MEMRD: if (bus.mem_ready) begin
          mdr   <= bus.mem_rdata;
          state <= MEMWB;
        end
        MEMWB: begin
          if (rt != 5'd0) regs[rt] <= mdr;
          state <= FETCH;
        end
        MEMWR: if (gpio_hit) begin
          GPIO_o <= b[GPIO_WIDTH-1:0];
          state  <= FETCH;
        end else if (bus.mem_ready) begin
          state <= FETCH;
        end
        ADDI: begin
          alu_out <= a + imm_sx;
          state   <= ADDIWB;
        end
        ADDIWB: begin
          if (rt != 5'd0) regs[rt] <= alu_out;
          state <= FETCH;
        end
        BRANCH: begin
          if (take_branch) pc <= alu_out;
          state <= FETCH;
        end
        JUMP: begin
          pc    <= {pc[31:28], ir[25:0], 2'b00};
          state <= FETCH;
        end
        HALT: ;
        default: begin
          state  <= HALT;
          halted <= 1'b1;
        end
      endcase

      // Wait counter restarts on every request; placed last so a timeout overrides the hold above.
      if (mem_busy && !bus.mem_ready) begin
        if (wait_cnt == WAIT_LAST) begin
          state   <= HALT;
          halted  <= 1'b1;
          timeout <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + WCW'(1);
        end
      end else begin
        wait_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mips_multi_cycle_core.sv
// Directed bench for mips_multi_cycle_core: small programs run against a wait-state memory model.
module tb_mips_multi_cycle_core;

  localparam logic [31:0] GPIO_ADDR = 32'hFFFF_0000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] gpio;
  logic       halted, timeout;

  mips_mem_if ifc ();

  mips_multi_cycle_core #(
    .RESET_PC(32'h0000_0000), .GPIO_WIDTH(8), .GPIO_ADDR(GPIO_ADDR), .WAIT_TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset), .bus(ifc), .GPIO_o(gpio), .halted(halted), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } hs_t;

  logic [31:0] mem [1024];
  hs_t         log_q [$];
  int          cyc, wcnt, wait_cfg, gpio_req_cnt;
  logic        no_resp;
  int          n_checks, n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic int fetch_cyc(logic [31:0] addr);
    foreach (log_q[i]) if (!log_q[i].we && log_q[i].addr == addr) return log_q[i].cyc;
    return -1;
  endfunction

  function automatic int store_cnt();
    int n = 0;
    foreach (log_q[i]) if (log_q[i].we) n++;
    return n;
  endfunction

  always @(posedge clk) begin
    if (reset) cyc = 0;
    else       cyc = cyc + 1;
  end

  // Memory model: decides ready shortly after each falling edge for the next rising edge.
  always begin
    @(negedge clk);
    #2;
    if (ifc.mem_req && !no_resp) begin
      if (ifc.mem_addr == GPIO_ADDR) gpio_req_cnt++;
      if (wcnt >= wait_cfg) begin
        ifc.mem_ready = 1'b1;
        ifc.mem_rdata = mem[ifc.mem_addr[11:2]];
        log_q.push_back('{cyc + 1, ifc.mem_addr, ifc.mem_we, ifc.mem_wdata});
        if (ifc.mem_we) mem[ifc.mem_addr[11:2]] = ifc.mem_wdata;
        wcnt = 0;
      end else begin
        ifc.mem_ready = 1'b0;
        ifc.mem_rdata = 32'hDEAD_BEEF;
        wcnt++;
      end
    end else begin
      ifc.mem_ready = 1'b0;
      wcnt = 0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
  endtask

  task automatic start(input int waits);
    reset    = 1'b1;
    wait_cfg = waits;
    no_resp  = 1'b0;
    step(2);
    log_q.delete();
    gpio_req_cnt = 0;
    reset = 1'b0;
  endtask

  task automatic load_p1();
    clear_mem();
    mem[0] = enc_i(6'h08, 0, 1, 16'd5);
    mem[1] = enc_i(6'h08, 0, 2, 16'd7);
    mem[2] = enc_r(1, 2, 3, 6'h20);
    mem[3] = enc_i(6'h04, 0, 0, 16'hFFFF);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; wcnt = 0; cyc = 0; gpio_req_cnt = 0;
    wait_cfg = 0; no_resp = 1'b0;
    ifc.mem_ready = 1'b0; ifc.mem_rdata = 32'h0;

    // Reset state
    load_p1();
    step(3);
    check("rst_req", {31'b0, ifc.mem_req}, 32'd0);
    check("rst_we", {31'b0, ifc.mem_we}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_timeout", {31'b0, timeout}, 32'd0);
    check("rst_gpio", {24'b0, gpio}, 32'd0);
    check("rst_pc", dut.pc, 32'h0);

    // addi/addi/add, zero wait
    start(0);
    step(20);
    check("p1_r1", dut.regs[1], 32'd5);
    check("p1_r2", dut.regs[2], 32'd7);
    check("p1_r3", dut.regs[3], 32'd12);
    check("p1_first_fetch", fetch_cyc(32'h0), 32'd1);
    check("p1_fetch4_cyc", fetch_cyc(32'hC), 32'd13);

    // sw / lw with 3 wait cycles per access
    clear_mem();
    mem[0] = enc_i(6'h08, 0, 3, 16'd12);
    mem[1] = enc_i(6'h2B, 0, 3, 16'h0100);
    mem[2] = enc_i(6'h23, 0, 4, 16'h0100);
    mem[3] = enc_i(6'h04, 0, 0, 16'hFFFF);
    start(3);
    step(60);
    check("p2_store_cnt", store_cnt(), 32'd1);
    foreach (log_q[i]) if (log_q[i].we) begin
      check("p2_store_data", log_q[i].wdata, 32'd12);
      check("p2_store_addr", log_q[i].addr, 32'h100);
    end
    check("p2_r4", dut.regs[4], 32'd12);
    check("p2_sw_cycles", fetch_cyc(32'h8) - fetch_cyc(32'h4), 32'd10);
    check("p2_lw_cycles", fetch_cyc(32'hC) - fetch_cyc(32'h8), 32'd11);

    // GPIO store: 0xFFFF8000 + signext(0x8000) wraps to GPIO_ADDR
    clear_mem();
    mem[0] = enc_i(6'h08, 0, 5, 16'h00A5);
    mem[1] = enc_i(6'h08, 0, 6, 16'h8000);
    mem[2] = enc_i(6'h2B, 6, 5, 16'h8000);
    mem[3] = enc_i(6'h04, 0, 0, 16'hFFFF);
    start(0);
    step(25);
    check("p3_gpio", {24'b0, gpio}, 32'hA5);
    check("p3_gpio_req", gpio_req_cnt, 32'd0);
    check("p3_store_cnt", store_cnt(), 32'd0);
    check("p3_sw_cycles", fetch_cyc(32'hC) - fetch_cyc(32'h8), 32'd4);

    // beq fall-through, bne (optional), self-loop
    clear_mem();
    mem[0] = enc_i(6'h08, 0, 1, 16'd3);
    mem[1] = enc_i(6'h08, 0, 2, 16'd4);
    mem[2] = enc_i(6'h04, 1, 2, 16'd2);
    mem[3] = enc_i(6'h05, 1, 2, 16'd2);
    mem[4] = enc_i(6'h08, 0, 7, 16'd1);
    mem[5] = enc_i(6'h08, 0, 7, 16'd2);
    mem[6] = enc_i(6'h08, 0, 8, 16'd9);
    mem[7] = enc_i(6'h04, 1, 1, 16'hFFFF);
    start(0);
    step(50);
    check("p4_beq_cycles", fetch_cyc(32'hC) - fetch_cyc(32'h8), 32'd3);
    check("p4_r7", dut.regs[7], 32'd0);
`ifdef MIPS_MC_BNE_EN
    check("p4_r8", dut.regs[8], 32'd9);
    check("p4_halted", {31'b0, halted}, 32'd0);
    check("p4_bne_cycles", fetch_cyc(32'h18) - fetch_cyc(32'hC), 32'd3);
    check("p4_loop_addr", log_q[log_q.size() - 1].addr, 32'h1C);
`else
    check("p4_r8", dut.regs[8], 32'd0);
    check("p4_halted", {31'b0, halted}, 32'd1);
    check("p4_timeout", {31'b0, timeout}, 32'd0);
    check("p4_req_halt", {31'b0, ifc.mem_req}, 32'd0);
    check("p4_last_fetch", log_q[log_q.size() - 1].addr, 32'hC);
`endif

    // Fetch timeout, then reset recovery
    load_p1();
    start(0);
    no_resp = 1'b1;
    step(15);
    check("to_not_yet", {31'b0, halted}, 32'd0);
    check("to_req_wait", {31'b0, ifc.mem_req}, 32'd1);
    step(1);
    check("to_halted", {31'b0, halted}, 32'd1);
    check("to_timeout", {31'b0, timeout}, 32'd1);
    step(3);
    check("to_req_off", {31'b0, ifc.mem_req}, 32'd0);
    reset = 1'b1;
    step(1);
    check("to_rst_halted", {31'b0, halted}, 32'd0);
    check("to_rst_timeout", {31'b0, timeout}, 32'd0);

    // Reset asserted mid-request drops it at once; refetch from RESET_PC
    start(3);
    step(2);
    check("mid_req_on", {31'b0, ifc.mem_req}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_req_drop", {31'b0, ifc.mem_req}, 32'd0);
    start(3);
    step(6);
    check("mid_refetch_cyc", fetch_cyc(32'h0), 32'd4);
    check("mid_refetch_pc", dut.pc, 32'h4);

    // ALU ops, $0 write discard, jump
    clear_mem();
    mem[0]  = enc_i(6'h08, 0, 1, 16'hFFFF);
    mem[1]  = enc_i(6'h08, 0, 2, 16'd1);
    mem[2]  = enc_r(1, 2, 3, 6'h2A);
    mem[3]  = enc_r(0, 2, 4, 6'h22);
    mem[4]  = enc_i(6'h08, 0, 0, 16'd9);
    mem[5]  = enc_r(1, 2, 5, 6'h24);
    mem[6]  = enc_r(4, 2, 6, 6'h25);
    mem[7]  = {6'h02, 26'd10};
    mem[8]  = enc_i(6'h08, 0, 7, 16'd1);
    mem[9]  = enc_i(6'h08, 0, 7, 16'd2);
    mem[10] = enc_r(2, 1, 8, 6'h2A);
    mem[11] = enc_i(6'h04, 0, 0, 16'hFFFF);
    start(0);
    step(60);
    check("alu_slt_neg", dut.regs[3], 32'd1);
    check("alu_sub", dut.regs[4], 32'hFFFF_FFFF);
    check("alu_r0", dut.regs[0], 32'd0);
    check("alu_and", dut.regs[5], 32'd1);
    check("alu_or", dut.regs[6], 32'hFFFF_FFFF);
    check("alu_j_skip", dut.regs[7], 32'd0);
    check("alu_slt_pos", dut.regs[8], 32'd0);
    check("alu_j_cycles", fetch_cyc(32'h28) - fetch_cyc(32'h1C), 32'd3);
    check("alu_halted", {31'b0, halted}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
